hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage core (F, D, E, M, W).
- Generates the stall and flush controls that the stage registers consume, including the flush into the decode-to-execute register.
- Keeps shadow copies of the destination-register and control fields for E, M and W, and uses them to compute forwarding selects for the execute-stage operand muxes.
- Sequences the multi-cycle branch recovery and counts inserted bubbles for performance monitoring.

---
 rtl/hazard_ctrl.sv | 166 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: load-use stalls, branch flush sequencing,
// execute-stage forwarding selects from shadow E/M/W fields, and a bubble counter.
module hazard_ctrl #(
    parameter int RBITS      = 4,
    parameter int PC_REG     = 15,
    parameter int BR_PENALTY = 1,
    parameter int CNT_BITS   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [RBITS-1:0]    ra1_d,
    input  logic [RBITS-1:0]    ra2_d,
    input  logic [RBITS-1:0]    wa3_d,
    input  logic                regwrite_d,
    input  logic                memtoreg_d,
    input  logic                branch_taken_e,
    output logic                stall_f,
    output logic                stall_d,
    output logic                flush_d,
    output logic                flush_e,
    output logic [1:0]          fwd_a_e,
    output logic [1:0]          fwd_b_e,
    output logic [CNT_BITS-1:0] bubble_cnt
);

    typedef enum logic {IDLE = 1'b0, RECOVER = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [2:0]           rcnt_q, rcnt_d;
    logic [RBITS-1:0]     ra1_e_q, ra1_e_d, ra2_e_q, ra2_e_d, wa3_e_q, wa3_e_d;
    logic                 regwrite_e_q, regwrite_e_d, memtoreg_e_q, memtoreg_e_d;
    logic [RBITS-1:0]     wa3_m_q, wa3_m_d, wa3_w_q, wa3_w_d;
    logic                 regwrite_m_q, regwrite_m_d, regwrite_w_q, regwrite_w_d;
    logic [CNT_BITS-1:0]  bubble_q, bubble_d;
    logic                 ldstall_s, stall_s, flush_d_s, flush_e_s;

    // The PC register is never a forwarding or load-use candidate.
    function automatic logic reg_match(input logic [RBITS-1:0] x, input logic [RBITS-1:0] y);
        return (x == y) && (y != RBITS'(PC_REG));
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [RBITS-1:0] ra,
                                           input logic rw_m, input logic [RBITS-1:0] wa_m,
                                           input logic rw_w, input logic [RBITS-1:0] wa_w);
        logic [1:0] sel;
        if (rw_m && reg_match(wa_m, ra)) begin
            sel = 2'b10;
        end else if (rw_w && reg_match(wa_w, ra)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Hazard decisions and next FSM state; a taken branch overrides any load-use stall.
    always_comb begin
        ldstall_s = memtoreg_e_q && regwrite_e_q &&
                    (reg_match(wa3_e_q, ra1_d) || reg_match(wa3_e_q, ra2_d));
        stall_s   = 1'b0;
        flush_d_s = 1'b0;
        flush_e_s = 1'b0;
        state_d   = state_q;
        rcnt_d    = rcnt_q;
        case (state_q)
            IDLE: begin
                if (branch_taken_e) begin
                    flush_d_s = 1'b1;
                    flush_e_s = 1'b1;
                    if (BR_PENALTY != 0) begin
                        state_d = RECOVER;
                        rcnt_d  = 3'(BR_PENALTY);
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    stall_s   = ldstall_s;
                    flush_e_s = ldstall_s;
                end
            end
            RECOVER: begin
                flush_d_s = 1'b1;
                flush_e_s = 1'b1;
                if (branch_taken_e) begin
                    rcnt_d = 3'(BR_PENALTY);
                end else if (rcnt_q == 3'd1) begin
                    state_d = IDLE;
                    rcnt_d  = 3'd0;
                end else begin
                    rcnt_d = rcnt_q - 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                rcnt_d  = 3'd0;
            end
        endcase
    end

    // Shadow pipeline advance and saturating bubble count.
    always_comb begin
        if (flush_e_s) begin
            ra1_e_d      = '0;
            ra2_e_d      = '0;
            wa3_e_d      = '0;
            regwrite_e_d = 1'b0;
            memtoreg_e_d = 1'b0;
        end else begin
            ra1_e_d      = ra1_d;
            ra2_e_d      = ra2_d;
            wa3_e_d      = wa3_d;
            regwrite_e_d = regwrite_d;
            memtoreg_e_d = memtoreg_d;
        end
        wa3_m_d      = wa3_e_q;
        regwrite_m_d = regwrite_e_q;
        wa3_w_d      = wa3_m_q;
        regwrite_w_d = regwrite_m_q;
        if (flush_e_s && (bubble_q != {CNT_BITS{1'b1}})) begin
            bubble_d = bubble_q + CNT_BITS'(1);
        end else begin
            bubble_d = bubble_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rcnt_q       <= 3'd0;
            ra1_e_q      <= '0;
            ra2_e_q      <= '0;
            wa3_e_q      <= '0;
            regwrite_e_q <= 1'b0;
            memtoreg_e_q <= 1'b0;
            wa3_m_q      <= '0;
            regwrite_m_q <= 1'b0;
            wa3_w_q      <= '0;
            regwrite_w_q <= 1'b0;
            bubble_q     <= '0;
        end else begin
            state_q      <= state_d;
            rcnt_q       <= rcnt_d;
            ra1_e_q      <= ra1_e_d;
            ra2_e_q      <= ra2_e_d;
            wa3_e_q      <= wa3_e_d;
            regwrite_e_q <= regwrite_e_d;
            memtoreg_e_q <= memtoreg_e_d;
            wa3_m_q      <= wa3_m_d;
            regwrite_m_q <= regwrite_m_d;
            wa3_w_q      <= wa3_w_d;
            regwrite_w_q <= regwrite_w_d;
            bubble_q     <= bubble_d;
        end
    end

    // Controls must be quiet while reset is held, even if a branch pulse arrives.
    assign stall_f    = stall_s & ~rst;
    assign stall_d    = stall_s & ~rst;
    assign flush_d    = flush_d_s & ~rst;
    assign flush_e    = flush_e_s & ~rst;
    assign fwd_a_e    = rst ? 2'b00 : fwd_sel(ra1_e_q, regwrite_m_q, wa3_m_q, regwrite_w_q, wa3_w_q);
    assign fwd_b_e    = rst ? 2'b00 : fwd_sel(ra2_e_q, regwrite_m_q, wa3_m_q, regwrite_w_q, wa3_w_q);
    assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: instance A (defaults) and instance B (BR_PENALTY=3, CNT_BITS=4)
// share stimulus; directed scenarios plus random traffic against an instruction-level model.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] ra1_d = 4'd0, ra2_d = 4'd0, wa3_d = 4'd0;
    logic       regwrite_d = 1'b0, memtoreg_d = 1'b0, branch_taken_e = 1'b0;

    logic        sf_a, sd_a, fd_a, fe_a, sf_b, sd_b, fd_b, fe_b;
    logic [1:0]  fa_a, fb_a, fa_b, fb_b;
    logic [15:0] bc_a;
    logic [3:0]  bc_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.RBITS(4), .PC_REG(15), .BR_PENALTY(1), .CNT_BITS(16)) dut_a (
        .clk(clk), .rst(rst), .ra1_d(ra1_d), .ra2_d(ra2_d), .wa3_d(wa3_d),
        .regwrite_d(regwrite_d), .memtoreg_d(memtoreg_d), .branch_taken_e(branch_taken_e),
        .stall_f(sf_a), .stall_d(sd_a), .flush_d(fd_a), .flush_e(fe_a),
        .fwd_a_e(fa_a), .fwd_b_e(fb_a), .bubble_cnt(bc_a));

    hazard_ctrl #(.RBITS(4), .PC_REG(15), .BR_PENALTY(3), .CNT_BITS(4)) dut_b (
        .clk(clk), .rst(rst), .ra1_d(ra1_d), .ra2_d(ra2_d), .wa3_d(wa3_d),
        .regwrite_d(regwrite_d), .memtoreg_d(memtoreg_d), .branch_taken_e(branch_taken_e),
        .stall_f(sf_b), .stall_d(sd_b), .flush_d(fd_b), .flush_e(fe_b),
        .fwd_a_e(fa_b), .fwd_b_e(fb_b), .bubble_cnt(bc_b));

    // Reference model: one instruction record per stage, per instance.
    typedef struct packed {
        logic [3:0] ra1, ra2, wa3;
        logic       rw, mtr;
    } instr_t;

    instr_t e_m[2], m_m[2], w_m[2];
    int     rem_m[2], cnt_m[2];
    int     penalty[2] = '{1, 3};
    int     cnt_max[2] = '{65535, 15};
    logic   x_sf[2], x_sd[2], x_fd[2], x_fe[2];
    logic [1:0] x_fa[2], x_fb[2];
    int     x_cnt[2];

    function automatic logic mt(input logic [3:0] x, input logic [3:0] y);
        return (x == y) && (y != 4'd15);
    endfunction

    function automatic logic [1:0] pick(input logic [3:0] ra, input instr_t m, input instr_t w);
        if (m.rw && mt(m.wa3, ra)) return 2'b10;
        if (w.rw && mt(w.wa3, ra)) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            e_m[d] = '0; m_m[d] = '0; w_m[d] = '0; rem_m[d] = 0; cnt_m[d] = 0;
        end
    endtask

    task automatic model_eval();
        for (int d = 0; d < 2; d++) begin
            logic ld, br;
            ld = e_m[d].mtr && e_m[d].rw && (mt(e_m[d].wa3, ra1_d) || mt(e_m[d].wa3, ra2_d));
            br = branch_taken_e || (rem_m[d] > 0);
            x_fd[d]  = !rst && br;
            x_sf[d]  = !rst && !br && ld;
            x_sd[d]  = x_sf[d];
            x_fe[d]  = x_fd[d] || x_sf[d];
            x_fa[d]  = rst ? 2'b00 : pick(e_m[d].ra1, m_m[d], w_m[d]);
            x_fb[d]  = rst ? 2'b00 : pick(e_m[d].ra2, m_m[d], w_m[d]);
            x_cnt[d] = cnt_m[d];
        end
    endtask

    task automatic model_advance();
        if (rst) begin
            model_reset();
        end else begin
            for (int d = 0; d < 2; d++) begin
                instr_t din;
                din = '{ra1: ra1_d, ra2: ra2_d, wa3: wa3_d, rw: regwrite_d, mtr: memtoreg_d};
                if (x_fe[d] && cnt_m[d] < cnt_max[d]) cnt_m[d]++;
                w_m[d] = m_m[d];
                m_m[d] = e_m[d];
                e_m[d] = x_fe[d] ? instr_t'(0) : din;
                if (branch_taken_e) rem_m[d] = penalty[d];
                else if (rem_m[d] > 0) rem_m[d]--;
            end
        end
    endtask

    // Advance one clock; afterwards we sit 1 time unit past the rising edge.
    task automatic tick();
        model_eval();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic set_d(input logic [3:0] r1, input logic [3:0] r2, input logic [3:0] w,
                         input logic rw, input logic mtr, input logic br);
        ra1_d = r1; ra2_d = r2; wa3_d = w; regwrite_d = rw; memtoreg_d = mtr; branch_taken_e = br;
    endtask

    task automatic apply_reset();
        set_d(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        model_reset();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        set_d(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        #2;
        vectors++;
        if (fd_a !== 1'b1) begin miscompares++; $display("FAIL reset_pre_flush got=%b want=1", fd_a); end
        rst = 1'b1;
        model_reset();
        #1;
        vectors++;
        if ({sf_a, sd_a, fd_a, fe_a, fa_a, fb_a, bc_a} !== 22'd0 ||
            {sf_b, sd_b, fd_b, fe_b, fa_b, fb_b, bc_b} !== 10'd0) begin
            miscompares++;
            $display("FAIL reset_async_outputs got_a=%b %b %b %b %b %b %h want all 0",
                     sf_a, sd_a, fd_a, fe_a, fa_a, fb_a, bc_a);
        end
        tick();
        set_d(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        #3;
        vectors++;
        if (fa_a !== 2'b00 || fb_a !== 2'b00 || sf_a !== 1'b0 || fe_a !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle got fwd=%b/%b stall=%b flush_e=%b want 00/00/0/0", fa_a, fb_a, sf_a, fe_a);
        end
    endtask

    task automatic test_forwarding();
        apply_reset();
        set_d(4'd0, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0); tick();
        set_d(4'd0, 4'd0, 4'd4, 1'b1, 1'b0, 1'b0); tick();
        set_d(4'd3, 4'd4, 4'd0, 1'b0, 1'b0, 1'b0); tick();
        set_d(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0); #3;
        vectors++;
        if (fa_a !== 2'b01 || fb_a !== 2'b10) begin
            miscompares++;
            $display("FAIL fwd_w_and_m got a=%b b=%b want a=01 b=10", fa_a, fb_a);
        end
        tick();
        set_d(4'd0, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0); tick();
        set_d(4'd0, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0); tick();
        set_d(4'd3, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0); tick();
        set_d(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0); #3;
        vectors++;
        if (fa_a !== 2'b10 || fb_a !== 2'b00) begin
            miscompares++;
            $display("FAIL fwd_m_priority got a=%b b=%b want a=10 b=00", fa_a, fb_a);
        end
        tick();
    endtask

    task automatic test_load_use();
        apply_reset();
        set_d(4'd0, 4'd0, 4'd2, 1'b1, 1'b1, 1'b0); tick();
        set_d(4'd2, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0); #3;
        vectors++;
        if ({sf_a, sd_a, fe_a, fd_a} !== 4'b1110 || bc_a !== 16'd0) begin
            miscompares++;
            $display("FAIL ldstall_assert got sf/sd/fe/fd=%b%b%b%b cnt=%0d want 1110 cnt=0",
                     sf_a, sd_a, fe_a, fd_a, bc_a);
        end
        tick(); #3;
        vectors++;
        if ({sf_a, sd_a, fe_a} !== 3'b000 || bc_a !== 16'd1) begin
            miscompares++;
            $display("FAIL ldstall_one_cycle got sf/sd/fe=%b%b%b cnt=%0d want 000 cnt=1", sf_a, sd_a, fe_a, bc_a);
        end
        tick();
        set_d(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0); #3;
        vectors++;
        if (fa_a !== 2'b01 || sf_a !== 1'b0) begin
            miscompares++;
            $display("FAIL ldstall_fwd got fwd_a=%b stall=%b want 01 0", fa_a, sf_a);
        end
        tick();
    endtask

    task automatic test_pc_exclusion();
        apply_reset();
        set_d(4'd0, 4'd0, 4'd15, 1'b1, 1'b1, 1'b0); tick();
        set_d(4'd15, 4'd15, 4'd0, 1'b0, 1'b0, 1'b0); #3;
        vectors++;
        if (sf_a !== 1'b0 || fe_a !== 1'b0) begin
            miscompares++;
            $display("FAIL pc_no_stall got stall=%b flush_e=%b want 0 0", sf_a, fe_a);
        end
        tick();
        set_d(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0); #3;
        vectors++;
        if (fa_a !== 2'b00 || fb_a !== 2'b00) begin
            miscompares++;
            $display("FAIL pc_no_fwd got a=%b b=%b want 00 00", fa_a, fb_a);
        end
        tick();
    endtask

    task automatic test_branch();
        apply_reset();
        set_d(4'd0, 4'd0, 4'd2, 1'b1, 1'b1, 1'b0); tick();
        set_d(4'd2, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1); #3;
        vectors++;
        if ({fd_a, fe_a, sf_a, sd_a} !== 4'b1100) begin
            miscompares++;
            $display("FAIL branch_beats_ldstall got fd/fe/sf/sd=%b%b%b%b want 1100", fd_a, fe_a, sf_a, sd_a);
        end
        tick();
        set_d(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0); #3;
        vectors++;
        if ({fd_a, fe_a} !== 2'b11 || {fd_b, fe_b} !== 2'b11) begin
            miscompares++;
            $display("FAIL branch_recover got a=%b%b b=%b%b want 11 11", fd_a, fe_a, fd_b, fe_b);
        end
        tick(); #3;
        vectors++;
        if ({fd_a, fe_a} !== 2'b00 || bc_a !== 16'd2 || fd_b !== 1'b1) begin
            miscompares++;
            $display("FAIL branch_done got a=%b%b cnt=%0d fd_b=%b want 00 cnt=2 fd_b=1", fd_a, fe_a, bc_a, fd_b);
        end
        tick(); tick(); #3;
        vectors++;
        if (fd_b !== 1'b0 || bc_b !== 4'd4) begin
            miscompares++;
            $display("FAIL branch_penalty3 got fd_b=%b cnt=%0d want 0 cnt=4", fd_b, bc_b);
        end
        tick();
    endtask

    task automatic test_saturation();
        apply_reset();
        set_d(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) tick();
        set_d(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        #3;
        vectors++;
        if (bc_b !== 4'd15 || bc_a !== 16'd21) begin
            miscompares++;
            $display("FAIL saturation got b=%0d a=%0d want b=15 a=21", bc_b, bc_a);
        end
        set_d(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1); tick(); #3;
        vectors++;
        if (bc_b !== 4'd15) begin
            miscompares++;
            $display("FAIL saturation_hold got %0d want 15", bc_b);
        end
        set_d(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_mid_recovery_reset();
        apply_reset();
        set_d(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1); tick();
        set_d(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0); #2;
        rst = 1'b1;
        model_reset();
        #1;
        vectors++;
        if (fd_b !== 1'b0 || fe_b !== 1'b0 || bc_b !== 4'd0) begin
            miscompares++;
            $display("FAIL midrec_reset got fd=%b fe=%b cnt=%0d want 0 0 0", fd_b, fe_b, bc_b);
        end
        tick();
        rst = 1'b0;
        tick(); #3;
        vectors++;
        if (fd_b !== 1'b0 || fd_a !== 1'b0) begin
            miscompares++;
            $display("FAIL midrec_idle got fd_b=%b fd_a=%b want 0 0", fd_b, fd_a);
        end
        tick();
    endtask

    task automatic test_random();
        logic       act_sf[2], act_sd[2], act_fd[2], act_fe[2];
        logic [1:0] act_fa[2], act_fb[2];
        int         act_cnt[2];
        apply_reset();
        for (int n = 0; n < 600; n++) begin
            logic [3:0] r1, r2, w;
            r1 = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            r2 = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            w  = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            set_d(r1, r2, w, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 11) == 0));
            #3;
            model_eval();
            act_sf = '{sf_a, sf_b}; act_sd = '{sd_a, sd_b};
            act_fd = '{fd_a, fd_b}; act_fe = '{fe_a, fe_b};
            act_fa = '{fa_a, fa_b}; act_fb = '{fb_a, fb_b};
            act_cnt = '{int'(bc_a), int'(bc_b)};
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (act_sf[d] !== x_sf[d] || act_sd[d] !== x_sd[d] || act_fd[d] !== x_fd[d] ||
                    act_fe[d] !== x_fe[d] || act_fa[d] !== x_fa[d] || act_fb[d] !== x_fb[d] ||
                    act_cnt[d] != x_cnt[d]) begin
                    miscompares++;
                    $display("FAIL random cyc=%0d dut=%0d got sf%b sd%b fd%b fe%b fa%b fb%b cnt%0d want sf%b sd%b fd%b fe%b fa%b fb%b cnt%0d",
                             n, d, act_sf[d], act_sd[d], act_fd[d], act_fe[d], act_fa[d], act_fb[d], act_cnt[d],
                             x_sf[d], x_sd[d], x_fd[d], x_fe[d], x_fa[d], x_fb[d], x_cnt[d]);
                end
            end
            tick();
        end
    endtask

    initial begin
        model_reset();
        #1;
        test_reset();
        test_forwarding();
        test_load_use();
        test_pc_exclusion();
        test_branch();
        test_saturation();
        test_mid_recovery_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
